// File: rtl/posit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : posit_pkg                                                     |
// | Description : Shared posit widths, special-value constants, flag struct    |
// |               and classification helpers for the posit multiply issue path. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package posit_pkg;

    localparam int POSIT_N  = 32;
    localparam int POSIT_ES = 4;

    // NaR is the sign bit alone; zero is all bits clear.
    localparam logic [POSIT_N-1:0] NAR  = {1'b1, {(POSIT_N-1){1'b0}}};
    localparam logic [POSIT_N-1:0] ZERO = '0;

    typedef struct packed {
        logic nar;
        logic zero;
    } posit_flags_t;

    function automatic logic is_nar(input logic [POSIT_N-1:0] v);
        return v == NAR;
    endfunction

    function automatic logic is_zero(input logic [POSIT_N-1:0] v);
        return v == ZERO;
    endfunction

endpackage : posit_pkg
`default_nettype wire

// File: rtl/posit_operand_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : posit_operand_fifo                                            |
// | Description : Show-ahead operand-pair FIFO with occupancy count and         |
// |               synchronous flush. Head entry is visible without a pop.       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module posit_operand_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    // Count (not pointer comparison) distinguishes full from empty.
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign w_wr  = push & ~full;
    assign w_rd  = pop & ~empty;
    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (!flush && w_wr) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); flush beats push/pop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
            else if (!w_wr && w_rd) r_count <= r_count - CW'(1);
        end
    end

endmodule : posit_operand_fifo
`default_nettype wire

// File: rtl/posit_mul_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : posit_mul_issue                                               |
// | Description : Issue stage around an external combinational posit           |
// |               multiplier: operand FIFO, head drive, registered product     |
// |               with {nar, zero} flags and valid/ready handshakes.           |
// |               Optional macro POSIT_SPECIAL_BYPASS_EN forces NaR/zero       |
// |               products from operand classification, ignoring mul_out.     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module posit_mul_issue
    import posit_pkg::*;
#(
    parameter int N     = POSIT_N,
    parameter int ES    = POSIT_ES,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_a,
    input  logic [N-1:0]            in_b,
    output logic [N-1:0]            mul_in1,
    output logic [N-1:0]            mul_in2,
    input  logic [N-1:0]            mul_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [N-1:0]            res_data,
    output logic [1:0]              res_flags,
    output logic [$clog2(DEPTH):0]  count
);
    localparam logic [N-1:0] C_NAR  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] C_ZERO = '0;

    // Elaboration guards on configuration legality.
    if (ES >= N - 1) begin : g_es_check
        $error("posit_mul_issue: ES must be smaller than N-1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("posit_mul_issue: DEPTH must be a power of two >= 2");
    end

    logic [2*N-1:0] w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic [N-1:0]   w_product;
    logic           r_res_valid;
    logic [N-1:0]   r_res_data;
    posit_flags_t   r_res_flags;

    assign in_ready = ~w_full;
    assign w_push   = in_valid & in_ready;
    assign w_pop    = ~w_empty & (~r_res_valid | res_ready);

    posit_operand_fifo #(
        .W     (2*N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .flush (flush),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({in_a, in_b}),
        .rdata (w_head),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Idle multiplier inputs are held at zero to keep its logic quiet.
    assign mul_in1 = w_empty ? '0 : w_head[2*N-1:N];
    assign mul_in2 = w_empty ? '0 : w_head[N-1:0];

`ifdef POSIT_SPECIAL_BYPASS_EN
    // Special operands decide the product here; multiplier output ignored.
    always_comb begin
        w_product = mul_out;
        if (mul_in1 == C_NAR || mul_in2 == C_NAR) begin
            w_product = C_NAR;
        end else if (mul_in1 == C_ZERO || mul_in2 == C_ZERO) begin
            w_product = C_ZERO;
        end
    end
`else
    assign w_product = mul_out;
`endif

    // Result register: load on pop, drop valid when consumed without refill.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_flags <= '0;
        end else if (flush) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_flags <= '0;
        end else if (w_pop) begin
            r_res_valid      <= 1'b1;
            r_res_data       <= w_product;
            r_res_flags.nar  <= (w_product == C_NAR);
            r_res_flags.zero <= (w_product == C_ZERO);
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_flags = r_res_flags;

endmodule : posit_mul_issue
`default_nettype wire

// File: tb/tb_posit_mul_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_posit_mul_issue                                            |
// | Description : Self-checking bench for posit_mul_issue. A stand-in          |
// |               multiplier drives mul_out; a queue-based reference model     |
// |               predicts every output each cycle.                             |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_posit_mul_issue;
    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_a;
    logic [N-1:0]      in_b;
    logic [N-1:0]      mul_in1;
    logic [N-1:0]      mul_in2;
    logic [N-1:0]      mul_out;
    logic              res_valid;
    logic              res_ready;
    logic [N-1:0]      res_data;
    logic [1:0]        res_flags;
    logic [2:0]        count;

    posit_mul_issue #(.N(N), .ES(4), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_in1   (mul_in1),
        .mul_in2   (mul_in2),
        .mul_out   (mul_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flags (res_flags),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: exact for the directed posit values, a hash otherwise.
    function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
        if (a == NAR || b == NAR || a == 0 || b == 0) begin
`ifdef POSIT_SPECIAL_BYPASS_EN
            return 32'h1234_5678;
`else
            return (a == NAR || b == NAR) ? NAR : 32'h0;
`endif
        end
        if (a == 32'h4000_0000) return b;
        if (b == 32'h4000_0000) return a;
        if (a == 32'h4200_0000 && b == 32'h4200_0000) return 32'h4400_0000;
        return (a * 32'h9E37_79B1) ^ b ^ (b << 7);
    endfunction

    always_comb mul_out = fake_mul(mul_in1, mul_in2);

    // Product the block must register: specials per posit rules, else the multiplier's answer.
    function automatic logic [31:0] ref_product(input logic [31:0] a, input logic [31:0] b);
`ifdef POSIT_SPECIAL_BYPASS_EN
        if (a == NAR || b == NAR) return NAR;
        if (a == 0 || b == 0) return 32'h0;
`endif
        return fake_mul(a, b);
    endfunction

    typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] d; logic [1:0] f; } vec_t;

    pair_t       mq[$];
    bit          m_rv;
    logic [31:0] m_rd;
    logic [1:0]  m_rf;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rv = 0;
        m_rd = '0;
        m_rf = '0;
    endtask

    task automatic compare_all();
        pair_t h;
        chk("count", 32'(count), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        chk("res_valid", 32'(res_valid), 32'(m_rv));
        chk("res_data", res_data, m_rd);
        chk("res_flags", 32'(res_flags), 32'(m_rf));
        if (mq.size() > 0) begin
            h = mq[0];
            chk("mul_in1", mul_in1, h.a);
            chk("mul_in2", mul_in2, h.b);
        end else begin
            chk("mul_in1_idle", mul_in1, 32'h0);
            chk("mul_in2_idle", mul_in2, 32'h0);
        end
    endtask

    // Advance the model over one clock with the current inputs, then check the DUT.
    task automatic tick();
        int          sz;
        bit          do_pop;
        bit          do_push;
        pair_t       h;
        logic [31:0] p;
        sz = mq.size();
        if (flush) begin
            model_reset();
        end else begin
            do_pop  = (sz > 0) && (!m_rv || res_ready);
            do_push = in_valid && (sz != DEPTH);
            if (do_pop) begin
                h    = mq.pop_front();
                p    = ref_product(h.a, h.b);
                m_rd = p;
                m_rf = {p == NAR, p == 32'h0};
                m_rv = 1;
            end else if (m_rv && res_ready) begin
                m_rv = 0;
            end
            if (do_push) mq.push_back('{a: in_a, b: in_b});
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_a = '0; in_b = '0; res_ready = 0;
    endtask

    initial begin
        vec_t vecs[6];
        int   acc;
        int   got;

        vecs[0] = '{a: 32'h4200_0000, b: 32'h4200_0000, d: 32'h4400_0000, f: 2'b00};
        vecs[1] = '{a: 32'h4000_0000, b: 32'hC000_0000, d: 32'hC000_0000, f: 2'b00};
        vecs[2] = '{a: 32'h4000_0000, b: 32'h4000_0000, d: 32'h4000_0000, f: 2'b00};
        vecs[3] = '{a: 32'h8000_0000, b: 32'h0000_0000, d: 32'h8000_0000, f: 2'b10};
        vecs[4] = '{a: 32'h0000_0000, b: 32'h4000_0000, d: 32'h0000_0000, f: 2'b01};
        vecs[5] = '{a: 32'h4400_0000, b: 32'h8000_0000, d: 32'h8000_0000, f: 2'b10};

        idle_inputs();
        n_rst = 0;
        model_reset();
        #12;
        compare_all();
        n_rst = 1;
        @(posedge clk); #1;

        // Directed single pairs: operands visible the cycle after push, product one edge later.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_a = vecs[i].a; in_b = vecs[i].b; res_ready = 1;
            tick();
            chk("vec_in1", mul_in1, vecs[i].a);
            chk("vec_in2", mul_in2, vecs[i].b);
            in_valid = 0;
            tick();
            chk("vec_valid", 32'(res_valid), 32'h1);
            chk("vec_data", res_data, vecs[i].d);
            chk("vec_flags", 32'(res_flags), 32'(vecs[i].f));
            tick();
        end

        // Back-to-back stream with free output.
        got = 0;
        res_ready = 1;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8); in_a = 32'h4000_0000; in_b = 32'hC000_0000;
            if (in_valid) chk("stream_in_ready", 32'(in_ready), 32'h1);
            tick();
            if (res_valid && res_data == 32'hC000_0000) got++;
        end
        chk("stream_results", 32'(got), 32'd8);
        in_valid = 0;
        tick();

        // Backpressure: FIFO plus result register absorb DEPTH+1 pairs.
        acc = 0;
        res_ready = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_a = 32'h1000 + 32'(i); in_b = 32'h2000 + 32'(i * 3);
            if (in_ready) acc++;
            tick();
        end
        chk("bp_accepted", 32'(acc), 32'(DEPTH + 1));
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        chk("bp_count", 32'(count), 32'(DEPTH));
        in_valid = 0; res_ready = 1;
        for (int i = 0; i < 7; i++) tick();
        chk("bp_drained", 32'(res_valid), 32'h0);

        // Mid-burst asynchronous reset at count=3.
        res_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_a = 32'h3000 + 32'(i); in_b = 32'h4000_0000;
            tick();
        end
        chk("pre_rst_count", 32'(count), 32'd3);
        in_valid = 0;
        #3 n_rst = 0;
        #1;
        model_reset();
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_valid", 32'(res_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        #1 n_rst = 1;
        tick();

        // Flush while push and pop are both requested at count=2.
        res_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_a = 32'h5000 + 32'(i); in_b = 32'h4200_0000;
            tick();
        end
        chk("pre_flush_count", 32'(count), 32'd2);
        flush = 1; in_valid = 1; res_ready = 1; in_a = 32'h6666; in_b = 32'h7777;
        tick();
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_valid", 32'(res_valid), 32'h0);
        chk("flush_in_ready", 32'(in_ready), 32'h1);
        idle_inputs();
        tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            flush     = ($urandom_range(0, 31) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            res_ready = $urandom_range(0, 2) != 0;
            case ($urandom_range(0, 9))
                0:       in_a = NAR;
                1:       in_a = 32'h0;
                default: in_a = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:       in_b = NAR;
                1:       in_b = 32'h0;
                default: in_b = $urandom;
            endcase
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_posit_mul_issue
`default_nettype wire
